// File: rtl/rf_preload_ctrl.sv
// Loads a valid/ready byte stream into consecutive register-file slots, then reads them back and checks an XOR checksum.
// Core writeback passes straight through to the register file whenever the controller is not loading or verifying.
module rf_preload_ctrl #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int FIRST = 0,
  parameter int COUNT = 2**D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         core_write_en,
  input  logic [D-1:0] core_dest_addr,
  input  logic [W-1:0] core_data_in,
  output logic         rf_write_en,
  output logic [D-1:0] rf_dest_addr,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out_dest,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [D-1:0]  FIRST_A = D'(FIRST);
  localparam logic [CW-1:0] LAST    = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t        state, state_nx;
  logic [D-1:0]  addr, addr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [W-1:0]  wsum, wsum_nx;
  logic [W-1:0]  rsum, rsum_nx;
  logic          chk_err, chk_err_nx;

  assign error = chk_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      wsum    <= '0;
      rsum    <= '0;
      chk_err <= 1'b0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      cnt     <= cnt_nx;
      wsum    <= wsum_nx;
      rsum    <= rsum_nx;
      chk_err <= chk_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    cnt_nx       = cnt;
    wsum_nx      = wsum;
    rsum_nx      = rsum;
    chk_err_nx   = chk_err;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    rf_write_en  = core_write_en;
    rf_dest_addr = core_dest_addr;
    rf_data_in   = core_data_in;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = LOAD;
          addr_nx    = FIRST_A;
          cnt_nx     = '0;
          wsum_nx    = '0;
          rsum_nx    = '0;
          chk_err_nx = 1'b0;
        end
      end

      LOAD: begin
        // Core writes are dropped here; the controller owns the write port.
        busy         = 1'b1;
        in_ready     = 1'b1;
        rf_write_en  = in_valid;
        rf_dest_addr = addr;
        rf_data_in   = in_data;
        if (in_valid) begin
          wsum_nx = wsum ^ in_data;
          if (cnt == LAST) begin
            state_nx = VERIFY;
            addr_nx  = FIRST_A;
            cnt_nx   = '0;
          end else begin
            addr_nx = addr + D'(1);
            cnt_nx  = cnt + CW'(1);
          end
        end
      end

      VERIFY: begin
        busy         = 1'b1;
        rf_write_en  = 1'b0;
        rf_dest_addr = addr;
        rf_data_in   = '0;
        rsum_nx      = rsum ^ rf_data_out_dest;
        addr_nx      = addr + D'(1);
        if (cnt == LAST) begin
          state_nx   = DONE;
          cnt_nx     = '0;
          chk_err_nx = ((rsum ^ rf_data_out_dest) != wsum);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_preload_ctrl.sv
// Bench for rf_preload_ctrl: default instance (a) plus a wrapped-range instance (b, FIRST=6, COUNT=4), each with a register-file model.
module tb_rf_preload_ctrl;

  logic       clk;
  logic       reset;

  logic       start_a, in_valid_a, in_ready_a;
  logic [7:0] in_data_a;
  logic       core_we_a;
  logic [2:0] core_addr_a;
  logic [7:0] core_din_a;
  logic       rf_we_a;
  logic [2:0] rf_addr_a;
  logic [7:0] rf_din_a, rf_dout_a;
  logic       busy_a, done_a, error_a;
  logic       flip;

  logic       start_b, in_valid_b, in_ready_b;
  logic [7:0] in_data_b;
  logic       core_we_b;
  logic [2:0] core_addr_b;
  logic [7:0] core_din_b;
  logic       rf_we_b;
  logic [2:0] rf_addr_b;
  logic [7:0] rf_din_b, rf_dout_b;
  logic       busy_b, done_b, error_b;

  logic [7:0]  rf_a [8];
  logic [7:0]  rf_b [8];
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int busy_cnt_a = 0;
  int done_cnt_a = 0;

  assign core_we_b   = 1'b0;
  assign core_addr_b = 3'd0;
  assign core_din_b  = 8'h00;

  rf_preload_ctrl u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .core_write_en(core_we_a), .core_dest_addr(core_addr_a), .core_data_in(core_din_a),
    .rf_write_en(rf_we_a), .rf_dest_addr(rf_addr_a), .rf_data_in(rf_din_a),
    .rf_data_out_dest(rf_dout_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  rf_preload_ctrl #(.W(8), .D(3), .FIRST(6), .COUNT(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .core_write_en(core_we_b), .core_dest_addr(core_addr_b), .core_data_in(core_din_b),
    .rf_write_en(rf_we_b), .rf_dest_addr(rf_addr_b), .rf_data_in(rf_din_b),
    .rf_data_out_dest(rf_dout_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Register-file models; file b is reset to a known pattern, file a never is.
  always @(posedge clk) begin
    if (rf_we_a) rf_a[rf_addr_a] <= rf_din_a;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_b[i] <= 8'hF0 + 8'(i);
    end else if (rf_we_b) begin
      rf_b[rf_addr_b] <= rf_din_b;
    end
  end

  assign rf_dout_a = rf_a[rf_addr_a] ^ {7'b0, flip};
  assign rf_dout_b = rf_b[rf_addr_b];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-port scoreboards: every controller-owned write must match the next expected (addr,data).
  always @(negedge clk) begin
    if (busy_a) busy_cnt_a++;
    if (done_a) done_cnt_a++;
    if (busy_a && rf_we_a === 1'b1) begin
      if (q_a.size() == 0) check_eq("sb_a_extra_write", 32'(rf_we_a), 32'd0);
      else check_eq("sb_a_write", 32'({5'b0, rf_addr_a, rf_din_a}), 32'(q_a.pop_front()));
    end
    if (busy_b && rf_we_b === 1'b1) begin
      if (q_b.size() == 0) check_eq("sb_b_extra_write", 32'(rf_we_b), 32'd0);
      else check_eq("sb_b_write", 32'({5'b0, rf_addr_b, rf_din_b}), 32'(q_b.pop_front()));
    end
  end

  task automatic start_pulse(input bit sel, output int t0);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = edge_cnt;
  endtask

  task automatic load_a(input logic [7:0] base, input logic [7:0] step, input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          in_valid_a = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid_a = 1'b1;
      in_data_a  = 8'(base + step * 8'(i));
      q_a.push_back({8'(i % 8), in_data_a});
      guard = 0;
      while (!in_ready_a && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      check_eq("in_ready_a", 32'(in_ready_a), 32'd1);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int t0, output int lat, output logic err);
    bit seen = 0;
    lat = -1;
    err = 1'bx;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin
        seen = 1;
        lat  = edge_cnt - t0;
        err  = sel ? error_b : error_a;
      end
    end
    check_eq(sel ? "done_seen_b" : "done_seen_a", 32'(seen), 32'd1);
  endtask

  int   t0, lat, bsnap, dsnap;
  logic err;

  initial begin
    reset = 1'b1;
    start_a = 0; in_valid_a = 0; in_data_a = 0; core_we_a = 0; core_addr_a = 0; core_din_a = 0; flip = 0;
    start_b = 0; in_valid_b = 0; in_data_b = 0;

    // Reset and core pass-through.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_error", 32'(error_a), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_a), 32'd0);
    core_we_a = 1'b1; core_addr_a = 3'd3; core_din_a = 8'h5A;
    #1;
    check_eq("pass_we", 32'(rf_we_a), 32'd1);
    check_eq("pass_addr_dat", 32'({rf_addr_a, rf_din_a}), 32'({3'd3, 8'h5A}));
    @(posedge clk); #1;
    core_we_a = 1'b0;
    check_eq("pass_reg3", 32'(rf_a[3]), 32'h5A);

    // Continuous stream 0x11..0x88.
    bsnap = busy_cnt_a;
    start_pulse(0, t0);
    load_a(8'h11, 8'h11, 8, 0);
    wait_done(0, t0, lat, err);
    check_eq("lat_cont", 32'(lat), 32'd16);
    check_eq("busy_cycles_cont", 32'(busy_cnt_a - bsnap), 32'd16);
    check_eq("err_cont", 32'(err), 32'd0);
    for (int i = 0; i < 8; i++) check_eq("regs_cont", 32'(rf_a[i]), 32'(8'h11 * 8'(i + 1)));

    // Same stream, valid pattern 1,0,0,1,...
    repeat (2) @(posedge clk); #1;
    start_pulse(0, t0);
    load_a(8'h11, 8'h11, 8, 2);
    wait_done(0, t0, lat, err);
    check_eq("lat_gap", 32'(lat), 32'd30);
    check_eq("err_gap", 32'(err), 32'd0);
    for (int i = 0; i < 8; i++) check_eq("regs_gap", 32'(rf_a[i]), 32'(8'h11 * 8'(i + 1)));

    // Core writes during LOAD are dropped; start during VERIFY ignored.
    repeat (2) @(posedge clk); #1;
    dsnap = done_cnt_a;
    start_pulse(0, t0);
    core_we_a = 1'b1; core_addr_a = 3'd2; core_din_a = 8'hEE;
    load_a(8'h30, 8'h01, 8, 1);
    core_we_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(0, t0, lat, err);
    check_eq("lat_gap1", 32'(lat), 32'd23);
    repeat (20) @(posedge clk); #1;
    check_eq("single_done", 32'(done_cnt_a - dsnap), 32'd1);
    check_eq("idle_after_stray_start", 32'(busy_a), 32'd0);
    check_eq("reg2_core_dropped", 32'(rf_a[2]), 32'h32);

    // Reset after 3 bytes of LOAD.
    dsnap = done_cnt_a;
    start_pulse(0, t0);
    load_a(8'hD0, 8'h01, 3, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midload_rst_busy", 32'(busy_a), 32'd0);
    repeat (40) @(posedge clk); #1;
    check_eq("midload_no_done", 32'(done_cnt_a - dsnap), 32'd0);
    for (int i = 0; i < 3; i++) check_eq("midload_regs", 32'(rf_a[i]), 32'(8'hD0 + 8'(i)));
    check_eq("midload_reg3_kept", 32'(rf_a[3]), 32'h33);

    // Corrupted read-back flags error until the next start.
    start_pulse(0, t0);
    load_a(8'h61, 8'h07, 8, 0);
    flip = 1'b1;
    @(posedge clk); #1;
    flip = 1'b0;
    wait_done(0, t0, lat, err);
    check_eq("flip_err_at_done", 32'(err), 32'd1);
    repeat (3) @(posedge clk); #1;
    check_eq("flip_err_held", 32'(error_a), 32'd1);
    start_pulse(0, t0);
    check_eq("err_cleared_by_start", 32'(error_a), 32'd0);
    load_a(8'h61, 8'h07, 8, 0);
    wait_done(0, t0, lat, err);
    check_eq("err_clean_rerun", 32'(err), 32'd0);

    // Instance b: FIRST=6, COUNT=4 wraps 6,7,0,1.
    repeat (2) @(posedge clk); #1;
    start_pulse(1, t0);
    for (int i = 0; i < 4; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = 8'hA0 + 8'(i);
      q_b.push_back({8'((6 + i) % 8), in_data_b});
      check_eq("in_ready_b", 32'(in_ready_b), 32'd1);
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    wait_done(1, t0, lat, err);
    check_eq("lat_b", 32'(lat), 32'd8);
    check_eq("err_b", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) check_eq("regs_b_loaded", 32'(rf_b[(6 + i) % 8]), 32'(8'hA0 + 8'(i)));
    for (int i = 2; i < 6; i++) check_eq("regs_b_untouched", 32'(rf_b[i]), 32'(8'hF0 + 8'(i)));

    repeat (2) @(posedge clk); #1;
    check_eq("sb_a_drained", 32'(q_a.size()), 32'd0);
    check_eq("sb_b_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion before 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
